// File: rtl/pid_incr_sat.sv
// Incremental (velocity-form) PID controller with a saturated signed output.
// A five-state sequencer runs one sample through DIFF, MULT, SUM and SAT stages.
module pid_incr_sat #(
  parameter int unsigned ERR_W   = 9,
  parameter int unsigned OUT_W   = 17,
  parameter int unsigned GAIN_W  = 8,
  parameter int unsigned FRAC_W  = 4,
  parameter int          OUT_MAX = (1 << (OUT_W - 1)) - 1,
  parameter int          OUT_MIN = -(1 << (OUT_W - 1))
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic signed [ERR_W-1:0]  err,
  input  logic                     err_valid,
  output logic                     err_ready,
  input  logic        [GAIN_W-1:0] kp,
  input  logic        [GAIN_W-1:0] ki,
  input  logic        [GAIN_W-1:0] kd,
  output logic signed [OUT_W-1:0]  uk,
  output logic                     uk_valid
);

  // Differences need two extra bits; products add the gain plus a sign bit.
  localparam int unsigned DW = ERR_W + 2;
  localparam int unsigned PW = DW + GAIN_W + 1;
  localparam int unsigned SW = PW + 2;
  localparam int unsigned AW = ((OUT_W > SW) ? OUT_W : SW) + 1;

  localparam logic signed [AW-1:0]    AccMax  = AW'(OUT_MAX);
  localparam logic signed [AW-1:0]    AccMin  = AW'(OUT_MIN);
  localparam logic signed [OUT_W-1:0] OutMaxV = OUT_W'(OUT_MAX);
  localparam logic signed [OUT_W-1:0] OutMinV = OUT_W'(OUT_MIN);

  typedef enum logic [2:0] {StIdle, StDiff, StMult, StSum, StSat} state_e;

  state_e state_q, state_d;

  logic signed [ERR_W-1:0]  e_q, e_d, e1_q, e1_d, e2_q, e2_d;
  logic        [GAIN_W-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [DW-1:0]     dp_q, dp_d, di_q, di_d, dd_q, dd_d;
  logic signed [PW-1:0]     pp_q, pp_d, pi_q, pi_d, pd_q, pd_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic signed [OUT_W-1:0]  uk_q, uk_d;
  logic                     uk_valid_q, uk_valid_d;

  logic signed [DW-1:0] e_s, e1_s, e2_s;
  logic signed [PW-1:0] kp_s, ki_s, kd_s;
  logic signed [SW-1:0] sum, delta;
  logic signed [AW-1:0] acc_new;
  logic signed [OUT_W-1:0] sat_val;

  always_comb begin
    e_s  = DW'(e_q);
    e1_s = DW'(e1_q);
    e2_s = DW'(e2_q);
    kp_s = $signed(PW'({1'b0, kp_q}));
    ki_s = $signed(PW'({1'b0, ki_q}));
    kd_s = $signed(PW'({1'b0, kd_q}));
    sum     = SW'(pp_q) + SW'(pi_q) + SW'(pd_q);
    delta   = sum >>> FRAC_W;
    // u_prev is the stored, already-saturated output: clamping it gives anti-windup.
    acc_new = AW'(uk_q) + AW'(delta);
    if (acc_q > AccMax) begin
      sat_val = OutMaxV;
    end else if (acc_q < AccMin) begin
      sat_val = OutMinV;
    end else begin
      sat_val = acc_q[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    e1_d       = e1_q;
    e2_d       = e2_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    kd_d       = kd_q;
    dp_d       = dp_q;
    di_d       = di_q;
    dd_d       = dd_q;
    pp_d       = pp_q;
    pi_d       = pi_q;
    pd_d       = pd_q;
    acc_d      = acc_q;
    uk_d       = uk_q;
    uk_valid_d = 1'b0;
    if (clr) begin
      state_d = StIdle;
      e1_d    = '0;
      e2_d    = '0;
      uk_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (err_valid) begin
            e_d     = err;
            kp_d    = kp;
            ki_d    = ki;
            kd_d    = kd;
            state_d = StDiff;
          end
        end
        StDiff: begin
          dp_d    = e_s - e1_s;
          di_d    = e_s;
          dd_d    = e_s - (e1_s <<< 1) + e2_s;
          state_d = StMult;
        end
        StMult: begin
          pp_d    = PW'(dp_q) * kp_s;
          pi_d    = PW'(di_q) * ki_s;
          pd_d    = PW'(dd_q) * kd_s;
          state_d = StSum;
        end
        StSum: begin
          acc_d   = acc_new;
          state_d = StSat;
        end
        StSat: begin
          uk_d       = sat_val;
          uk_valid_d = 1'b1;
          e2_d       = e1_q;
          e1_d       = e_q;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      e_q        <= '0;
      e1_q       <= '0;
      e2_q       <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      kd_q       <= '0;
      dp_q       <= '0;
      di_q       <= '0;
      dd_q       <= '0;
      pp_q       <= '0;
      pi_q       <= '0;
      pd_q       <= '0;
      acc_q      <= '0;
      uk_q       <= '0;
      uk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      e1_q       <= e1_d;
      e2_q       <= e2_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
      dp_q       <= dp_d;
      di_q       <= di_d;
      dd_q       <= dd_d;
      pp_q       <= pp_d;
      pi_q       <= pi_d;
      pd_q       <= pd_d;
      acc_q      <= acc_d;
      uk_q       <= uk_d;
      uk_valid_q <= uk_valid_d;
    end
  end

  assign err_ready = (state_q == StIdle);
  assign uk        = uk_q;
  assign uk_valid  = uk_valid_q;

endmodule
